// File: rtl/h_row_streamer_if.sv
// Handshake bundle for h_row_streamer: row descriptor input, nonzero element
// input, assembled row output and the sticky overflow flag.
interface h_row_streamer_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_OF_COLS = 5,
   parameter int MAX_ROW_LEN = 4,
   parameter int NUM_OF_ROWS = 5
) ();
   localparam int COL_IDX_WIDTH = $clog2(NUM_OF_COLS);
   localparam int LEN_IN_WIDTH  = $clog2(NUM_OF_COLS + 1);
   localparam int ROW_LEN_WIDTH = $clog2(MAX_ROW_LEN + 1);
   localparam int ROW_IDX_WIDTH = $clog2(NUM_OF_ROWS);

   logic                     info_valid_i;
   logic                     info_ready_o;
   logic [LEN_IN_WIDTH-1:0]  info_row_len_i;
   logic                     info_flag_i;

   logic                     nz_valid_i;
   logic                     nz_ready_o;
   logic [COL_IDX_WIDTH-1:0] nz_col_idx_i;
   logic [DATA_WIDTH-1:0]    nz_value_i;

   logic                     row_valid_o;
   logic                     row_ready_i;
   logic [COL_IDX_WIDTH-1:0] row_col_idx_o [MAX_ROW_LEN];
   logic [DATA_WIDTH-1:0]    row_value_o   [MAX_ROW_LEN];
   logic [MAX_ROW_LEN-1:0]   row_mask_o;
   logic [ROW_LEN_WIDTH-1:0] row_len_o;
   logic                     row_flag_o;
   logic [ROW_IDX_WIDTH-1:0] row_idx_o;
   logic                     row_last_o;
   logic                     overflow_o;

   // Streamer side
   modport slave (
      input  info_valid_i, info_row_len_i, info_flag_i,
      input  nz_valid_i, nz_col_idx_i, nz_value_i,
      input  row_ready_i,
      output info_ready_o, nz_ready_o,
      output row_valid_o, row_col_idx_o, row_value_o, row_mask_o,
      output row_len_o, row_flag_o, row_idx_o, row_last_o, overflow_o
   );

   // Environment side
   modport master (
      output info_valid_i, info_row_len_i, info_flag_i,
      output nz_valid_i, nz_col_idx_i, nz_value_i,
      output row_ready_i,
      input  info_ready_o, nz_ready_o,
      input  row_valid_o, row_col_idx_o, row_value_o, row_mask_o,
      input  row_len_o, row_flag_o, row_idx_o, row_last_o, overflow_o
   );
endinterface

// File: rtl/h_row_streamer.sv
// Sparse row assembler: takes a row descriptor (length, flag), collects that
// many (column, value) nonzeros into fixed slots, then presents the whole row
// until downstream accepts it. Elements beyond MAX_ROW_LEN are consumed and
// dropped, and a sticky overflow flag records that it happened.
module h_row_streamer #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_OF_COLS = 5,
   parameter int MAX_ROW_LEN = 4,
   parameter int NUM_OF_ROWS = 5
) (
   input logic               clk,
   input logic               rst,
   h_row_streamer_if.slave   bus
);
   localparam int COL_IDX_WIDTH = $clog2(NUM_OF_COLS);
   localparam int LEN_IN_WIDTH  = $clog2(NUM_OF_COLS + 1);
   localparam int ROW_LEN_WIDTH = $clog2(MAX_ROW_LEN + 1);
   localparam int ROW_IDX_WIDTH = $clog2(NUM_OF_ROWS);

   typedef enum logic [1:0] {
      S_INFO    = 2'd0,
      S_COLLECT = 2'd1,
      S_EMIT    = 2'd2
   } state_t;

   state_t                   state_r;
   logic [LEN_IN_WIDTH-1:0]  cnt_r;
   logic [LEN_IN_WIDTH-1:0]  len_r;
   logic                     flag_r;
   logic [ROW_LEN_WIDTH-1:0] row_len_r;
   logic [ROW_IDX_WIDTH-1:0] row_idx_r;
   logic                     row_last_r;
   logic [MAX_ROW_LEN-1:0]   mask_r;
   logic [COL_IDX_WIDTH-1:0] col_r [MAX_ROW_LEN];
   logic [DATA_WIDTH-1:0]    val_r [MAX_ROW_LEN];
   logic                     overflow_r;
   logic                     info_ready_r;
   logic                     nz_ready_r;
   logic                     row_valid_r;

   // Row FSM with all datapath state and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_INFO;
         cnt_r        <= {LEN_IN_WIDTH{1'b0}};
         len_r        <= {LEN_IN_WIDTH{1'b0}};
         flag_r       <= 1'b0;
         row_len_r    <= {ROW_LEN_WIDTH{1'b0}};
         row_idx_r    <= {ROW_IDX_WIDTH{1'b0}};
         row_last_r   <= 1'b0;
         mask_r       <= {MAX_ROW_LEN{1'b0}};
         overflow_r   <= 1'b0;
         info_ready_r <= 1'b1;
         nz_ready_r   <= 1'b0;
         row_valid_r  <= 1'b0;
         for (int k = 0; k < MAX_ROW_LEN; k++) begin
            col_r[k] <= {COL_IDX_WIDTH{1'b0}};
            val_r[k] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         case (state_r)
            S_INFO: begin
               if (bus.info_valid_i) begin
                  len_r  <= bus.info_row_len_i;
                  flag_r <= bus.info_flag_i;
                  cnt_r  <= {LEN_IN_WIDTH{1'b0}};
                  mask_r <= {MAX_ROW_LEN{1'b0}};
                  for (int k = 0; k < MAX_ROW_LEN; k++) begin
                     col_r[k] <= {COL_IDX_WIDTH{1'b0}};
                     val_r[k] <= {DATA_WIDTH{1'b0}};
                  end
                  // Stored length saturates; the excess is only flagged
                  if (int'(bus.info_row_len_i) > MAX_ROW_LEN) begin
                     row_len_r  <= ROW_LEN_WIDTH'(MAX_ROW_LEN);
                     overflow_r <= 1'b1;
                  end else begin
                     row_len_r  <= ROW_LEN_WIDTH'(bus.info_row_len_i);
                  end
                  info_ready_r <= 1'b0;
                  if (bus.info_row_len_i == {LEN_IN_WIDTH{1'b0}}) begin
                     state_r     <= S_EMIT;
                     row_valid_r <= 1'b1;
                  end else begin
                     state_r    <= S_COLLECT;
                     nz_ready_r <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (bus.nz_valid_i) begin
                  // Slot write only when cnt addresses an existing slot
                  for (int k = 0; k < MAX_ROW_LEN; k++) begin
                     if (int'(cnt_r) == k) begin
                        col_r[k]  <= bus.nz_col_idx_i;
                        val_r[k]  <= bus.nz_value_i;
                        mask_r[k] <= 1'b1;
                     end
                  end
                  cnt_r <= cnt_r + LEN_IN_WIDTH'(1);
                  if (int'(cnt_r) == int'(len_r) - 1) begin
                     state_r     <= S_EMIT;
                     nz_ready_r  <= 1'b0;
                     row_valid_r <= 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (bus.row_ready_i) begin
                  state_r      <= S_INFO;
                  row_valid_r  <= 1'b0;
                  info_ready_r <= 1'b1;
                  row_last_r   <= (int'(row_idx_r) == NUM_OF_ROWS - 2);
                  if (int'(row_idx_r) == NUM_OF_ROWS - 1) begin
                     row_idx_r <= {ROW_IDX_WIDTH{1'b0}};
                  end else begin
                     row_idx_r <= row_idx_r + ROW_IDX_WIDTH'(1);
                  end
               end
            end
            default: begin
               state_r      <= S_INFO;
               info_ready_r <= 1'b1;
               nz_ready_r   <= 1'b0;
               row_valid_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.info_ready_o  = info_ready_r;
   assign bus.nz_ready_o    = nz_ready_r;
   assign bus.row_valid_o   = row_valid_r;
   assign bus.row_col_idx_o = col_r;
   assign bus.row_value_o   = val_r;
   assign bus.row_mask_o    = mask_r;
   assign bus.row_len_o     = row_len_r;
   assign bus.row_flag_o    = flag_r;
   assign bus.row_idx_o     = row_idx_r;
   assign bus.row_last_o    = row_last_r;
   assign bus.overflow_o    = overflow_r;
endmodule

// File: tb/tb_h_row_streamer.sv
// Directed bench for h_row_streamer with default parameters.
module tb_h_row_streamer;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   h_row_streamer_if #(.DATA_WIDTH(8), .NUM_OF_COLS(5), .MAX_ROW_LEN(4), .NUM_OF_ROWS(5)) bus ();

   h_row_streamer #(.DATA_WIDTH(8), .NUM_OF_COLS(5), .MAX_ROW_LEN(4), .NUM_OF_ROWS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // One clock, then settle away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_info(input logic [2:0] len, input logic flag);
      bus.info_valid_i   = 1'b1;
      bus.info_row_len_i = len;
      bus.info_flag_i    = flag;
      tick();
      bus.info_valid_i   = 1'b0;
   endtask

   task automatic drive_nz(input logic [2:0] col, input logic [7:0] val);
      bus.nz_valid_i   = 1'b1;
      bus.nz_col_idx_i = col;
      bus.nz_value_i   = val;
      tick();
      bus.nz_valid_i   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.info_valid_i = 1'b1; bus.info_row_len_i = 3'd2; bus.info_flag_i = 1'b1;
      bus.nz_valid_i = 1'b1; bus.nz_col_idx_i = 3'd3; bus.nz_value_i = 8'hAB;
      bus.row_ready_i = 1'b0;
      tick(); tick();
      bus.info_valid_i = 1'b0; bus.nz_valid_i = 1'b0;
      rst = 1'b0;
      n_cmp++; if (bus.info_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_info_ready: got %b want 1", bus.info_ready_o); end
      n_cmp++; if (bus.nz_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_nz_ready: got %b want 0", bus.nz_ready_o); end
      n_cmp++; if (bus.row_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_row_valid: got %b want 0", bus.row_valid_o); end
      n_cmp++; if (bus.row_mask_o !== 4'b0000) begin n_err++; $display("FAIL rst_mask: got %b want 0000", bus.row_mask_o); end
      n_cmp++; if (bus.row_len_o !== 3'd0) begin n_err++; $display("FAIL rst_len: got %0d want 0", bus.row_len_o); end
      n_cmp++; if (bus.row_idx_o !== 3'd0 || bus.row_last_o !== 1'b0 || bus.row_flag_o !== 1'b0) begin
         n_err++; $display("FAIL rst_idx_last_flag: got %0d/%b/%b want 0/0/0", bus.row_idx_o, bus.row_last_o, bus.row_flag_o); end
      n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", bus.overflow_o); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (bus.row_col_idx_o[k] !== 3'd0 || bus.row_value_o[k] !== 8'h00) begin
            n_err++; $display("FAIL rst_slot%0d: got %0d/%h want 0/00", k, bus.row_col_idx_o[k], bus.row_value_o[k]);
         end
      end
   endtask

   task automatic test_basic();
      logic [2:0] ec [4];
      logic [7:0] ev [4];
      ec = '{3'd2, 3'd4, 3'd0, 3'd0};
      ev = '{8'h11, 8'h22, 8'h33, 8'h00};
      bus.row_ready_i = 1'b1;
      drive_info(3'd3, 1'b1);
      n_cmp++; if (bus.nz_ready_o !== 1'b1 || bus.info_ready_o !== 1'b0) begin
         n_err++; $display("FAIL basic_collect_ready: got nz=%b info=%b want 1/0", bus.nz_ready_o, bus.info_ready_o); end
      drive_nz(3'd2, 8'h11);
      drive_nz(3'd4, 8'h22);
      n_cmp++; if (bus.row_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", bus.row_valid_o); end
      drive_nz(3'd0, 8'h33);
      n_cmp++; if (bus.row_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", bus.row_valid_o); end
      n_cmp++; if (bus.row_mask_o !== 4'b0111) begin n_err++; $display("FAIL basic_mask: got %b want 0111", bus.row_mask_o); end
      n_cmp++; if (bus.row_len_o !== 3'd3 || bus.row_flag_o !== 1'b1 || bus.row_idx_o !== 3'd0) begin
         n_err++; $display("FAIL basic_len_flag_idx: got %0d/%b/%0d want 3/1/0", bus.row_len_o, bus.row_flag_o, bus.row_idx_o); end
      n_cmp++; if (bus.nz_ready_o !== 1'b0) begin n_err++; $display("FAIL basic_nz_ready_emit: got %b want 0", bus.nz_ready_o); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (bus.row_col_idx_o[k] !== ec[k] || bus.row_value_o[k] !== ev[k]) begin
            n_err++; $display("FAIL basic_slot%0d: got %0d/%h want %0d/%h", k, bus.row_col_idx_o[k], bus.row_value_o[k], ec[k], ev[k]);
         end
      end
      tick();
      n_cmp++; if (bus.row_valid_o !== 1'b0 || bus.info_ready_o !== 1'b1) begin
         n_err++; $display("FAIL basic_return: got valid=%b info=%b want 0/1", bus.row_valid_o, bus.info_ready_o); end
   endtask

   task automatic test_zero_len();
      bus.nz_valid_i = 1'b1; bus.nz_col_idx_i = 3'd1; bus.nz_value_i = 8'hEE;
      tick();
      n_cmp++; if (bus.nz_ready_o !== 1'b0 || bus.info_ready_o !== 1'b1) begin
         n_err++; $display("FAIL zero_idle_nz: got nz=%b info=%b want 0/1", bus.nz_ready_o, bus.info_ready_o); end
      bus.info_valid_i = 1'b1; bus.info_row_len_i = 3'd0; bus.info_flag_i = 1'b0;
      tick();
      bus.info_valid_i = 1'b0;
      n_cmp++; if (bus.row_valid_o !== 1'b1 || bus.nz_ready_o !== 1'b0) begin
         n_err++; $display("FAIL zero_valid: got valid=%b nz=%b want 1/0", bus.row_valid_o, bus.nz_ready_o); end
      n_cmp++; if (bus.row_mask_o !== 4'b0000 || bus.row_len_o !== 3'd0 || bus.row_idx_o !== 3'd1) begin
         n_err++; $display("FAIL zero_mask_len_idx: got %b/%0d/%0d want 0000/0/1", bus.row_mask_o, bus.row_len_o, bus.row_idx_o); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (bus.row_col_idx_o[k] !== 3'd0 || bus.row_value_o[k] !== 8'h00) begin
            n_err++; $display("FAIL zero_slot%0d: got %0d/%h want 0/00", k, bus.row_col_idx_o[k], bus.row_value_o[k]);
         end
      end
      tick();
      n_cmp++; if (bus.info_ready_o !== 1'b1 || bus.nz_ready_o !== 1'b0) begin
         n_err++; $display("FAIL zero_return: got info=%b nz=%b want 1/0", bus.info_ready_o, bus.nz_ready_o); end
      bus.nz_valid_i = 1'b0;
   endtask

   task automatic test_overflow();
      drive_info(3'd5, 1'b0);
      drive_nz(3'd1, 8'hA1);
      drive_nz(3'd3, 8'hA2);
      drive_nz(3'd0, 8'hA3);
      drive_nz(3'd2, 8'hA4);
      n_cmp++; if (bus.nz_ready_o !== 1'b1 || bus.row_valid_o !== 1'b0) begin
         n_err++; $display("FAIL ovf_still_collect: got nz=%b valid=%b want 1/0", bus.nz_ready_o, bus.row_valid_o); end
      drive_nz(3'd4, 8'hA5);
      n_cmp++; if (bus.row_valid_o !== 1'b1 || bus.row_len_o !== 3'd4 || bus.row_mask_o !== 4'b1111) begin
         n_err++; $display("FAIL ovf_row: got valid=%b len=%0d mask=%b want 1/4/1111", bus.row_valid_o, bus.row_len_o, bus.row_mask_o); end
      n_cmp++; if (bus.row_col_idx_o[3] !== 3'd2 || bus.row_value_o[3] !== 8'hA4) begin
         n_err++; $display("FAIL ovf_slot3: got %0d/%h want 2/a4", bus.row_col_idx_o[3], bus.row_value_o[3]); end
      n_cmp++; if (bus.row_col_idx_o[0] !== 3'd1 || bus.row_value_o[0] !== 8'hA1) begin
         n_err++; $display("FAIL ovf_slot0: got %0d/%h want 1/a1", bus.row_col_idx_o[0], bus.row_value_o[0]); end
      n_cmp++; if (bus.overflow_o !== 1'b1 || bus.row_idx_o !== 3'd2) begin
         n_err++; $display("FAIL ovf_flag_idx: got %b/%0d want 1/2", bus.overflow_o, bus.row_idx_o); end
      tick();
      drive_info(3'd1, 1'b1);
      drive_nz(3'd4, 8'h55);
      n_cmp++; if (bus.overflow_o !== 1'b1 || bus.row_len_o !== 3'd1 || bus.row_mask_o !== 4'b0001 || bus.row_idx_o !== 3'd3) begin
         n_err++; $display("FAIL ovf_next_row: got ovf=%b len=%0d mask=%b idx=%0d want 1/1/0001/3", bus.overflow_o, bus.row_len_o, bus.row_mask_o, bus.row_idx_o); end
      n_cmp++; if (bus.row_value_o[0] !== 8'h55 || bus.row_value_o[1] !== 8'h00 || bus.row_col_idx_o[3] !== 3'd0) begin
         n_err++; $display("FAIL ovf_next_slots: got %h/%h/%0d want 55/00/0", bus.row_value_o[0], bus.row_value_o[1], bus.row_col_idx_o[3]); end
      tick();
   endtask

   task automatic test_stall();
      bus.row_ready_i = 1'b0;
      drive_info(3'd2, 1'b1);
      drive_nz(3'd1, 8'h0F);
      drive_nz(3'd3, 8'hF0);
      bus.info_valid_i = 1'b1; bus.info_row_len_i = 3'd1; bus.info_flag_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_cmp++;
         if (bus.row_valid_o !== 1'b1 || bus.info_ready_o !== 1'b0 || bus.row_mask_o !== 4'b0011 ||
             bus.row_len_o !== 3'd2 || bus.row_col_idx_o[1] !== 3'd3 || bus.row_value_o[1] !== 8'hF0 ||
             bus.row_idx_o !== 3'd4 || bus.row_last_o !== 1'b1) begin
            n_err++; $display("FAIL stall_hold_c%0d: got v=%b ir=%b m=%b l=%0d c1=%0d v1=%h i=%0d last=%b want 1/0/0011/2/3/f0/4/1",
               c, bus.row_valid_o, bus.info_ready_o, bus.row_mask_o, bus.row_len_o, bus.row_col_idx_o[1], bus.row_value_o[1], bus.row_idx_o, bus.row_last_o);
         end
         tick();
      end
      bus.row_ready_i = 1'b1;
      tick();
      n_cmp++; if (bus.info_ready_o !== 1'b1 || bus.row_valid_o !== 1'b0) begin
         n_err++; $display("FAIL stall_after_hs: got info=%b valid=%b want 1/0", bus.info_ready_o, bus.row_valid_o); end
      tick();
      bus.info_valid_i = 1'b0;
      n_cmp++; if (bus.nz_ready_o !== 1'b1 || bus.info_ready_o !== 1'b0) begin
         n_err++; $display("FAIL stall_info_taken: got nz=%b info=%b want 1/0", bus.nz_ready_o, bus.info_ready_o); end
      drive_nz(3'd2, 8'h77);
      n_cmp++; if (bus.row_valid_o !== 1'b1 || bus.row_idx_o !== 3'd0 || bus.row_last_o !== 1'b0 || bus.row_flag_o !== 1'b0) begin
         n_err++; $display("FAIL stall_wrap_row: got v=%b idx=%0d last=%b flag=%b want 1/0/0/0", bus.row_valid_o, bus.row_idx_o, bus.row_last_o, bus.row_flag_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      rst = 1'b1; tick(); rst = 1'b0;
      bus.row_ready_i = 1'b1;
      for (int r = 0; r < 6; r++) begin
         logic [2:0] exp_idx;
         logic       exp_last;
         exp_idx  = (r == 5) ? 3'd0 : 3'(r);
         exp_last = (r == 4) ? 1'b1 : 1'b0;
         drive_info(3'd1, 1'b0);
         drive_nz(3'(r % 5), 8'(8'h40 + r));
         n_cmp++;
         if (bus.row_valid_o !== 1'b1 || bus.row_idx_o !== exp_idx || bus.row_last_o !== exp_last) begin
            n_err++; $display("FAIL b2b_row%0d: got v=%b idx=%0d last=%b want 1/%0d/%b", r, bus.row_valid_o, bus.row_idx_o, bus.row_last_o, exp_idx, exp_last);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      drive_info(3'd3, 1'b1);
      drive_nz(3'd1, 8'h99);
      drive_nz(3'd2, 8'h88);
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++; if (bus.info_ready_o !== 1'b1 || bus.nz_ready_o !== 1'b0 || bus.row_valid_o !== 1'b0) begin
         n_err++; $display("FAIL midrst_state: got info=%b nz=%b valid=%b want 1/0/0", bus.info_ready_o, bus.nz_ready_o, bus.row_valid_o); end
      tick();
      n_cmp++; if (bus.row_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_no_emit: got %b want 0", bus.row_valid_o); end
      drive_info(3'd1, 1'b0);
      drive_nz(3'd3, 8'h44);
      n_cmp++; if (bus.row_valid_o !== 1'b1 || bus.row_idx_o !== 3'd0 || bus.row_mask_o !== 4'b0001) begin
         n_err++; $display("FAIL midrst_row: got v=%b idx=%0d mask=%b want 1/0/0001", bus.row_valid_o, bus.row_idx_o, bus.row_mask_o); end
      n_cmp++; if (bus.row_value_o[0] !== 8'h44 || bus.row_value_o[1] !== 8'h00 || bus.row_col_idx_o[1] !== 3'd0) begin
         n_err++; $display("FAIL midrst_slots: got %h/%h/%0d want 44/00/0", bus.row_value_o[0], bus.row_value_o[1], bus.row_col_idx_o[1]); end
      tick();
   endtask

   initial begin
      bus.info_valid_i = 1'b0; bus.info_row_len_i = 3'd0; bus.info_flag_i = 1'b0;
      bus.nz_valid_i = 1'b0; bus.nz_col_idx_i = 3'd0; bus.nz_value_i = 8'h00;
      bus.row_ready_i = 1'b0;
      rst = 1'b1;
      test_reset();
      test_basic();
      test_zero_len();
      test_overflow();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
